// File: rtl/cdc_fifo_read_streamer.sv
// Read-domain sequencer: issues FIFO reads, absorbs the 1-cycle RAM latency and streams words from a 2-entry buffer.
// Empty falls in cycle N -> m_valid in N+2; with m_ready low, reads stop once buffered plus in-flight words reach 2.
module cdc_fifo_read_streamer #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_inc,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  logic [1:0]            occupancy;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic [1:0]            occupancy_next;

  assign m_valid = (occupancy != 2'd0);
  assign m_data  = head;
  assign pop     = m_valid && m_ready;

  // occupancy + inflight never exceeds 2 and pop implies occupancy >= 1, so 2 bits cannot wrap
  assign occupancy_next = occupancy + {1'b0, inflight} - {1'b0, pop};
  assign fifo_rd_inc    = rst_n && !fifo_empty && (occupancy_next < 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= 2'd0;
      inflight  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      rd_count  <= '0;
    end else begin
      occupancy <= occupancy_next;
      inflight  <= fifo_rd_inc;
      if (pop) begin
        rd_count <= rd_count + COUNT_WIDTH'(1);
      end
      if (inflight && ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop))) begin
        head <= fifo_rd_data;
      end else if (pop && (occupancy == 2'd2)) begin
        head <= tail;
      end
      if (inflight && (((occupancy == 2'd1) && !pop) || ((occupancy == 2'd2) && pop))) begin
        tail <= fifo_rd_data;
      end
    end
  end

  a_occupancy_max: assert property (@(posedge clk) disable iff (!rst_n)
    (occupancy != 2'd3) && ({1'b0, occupancy} + {2'b0, inflight} <= 3'd2));
  a_no_read_when_empty: assert property (@(posedge clk) !(fifo_rd_inc && fifo_empty));

endmodule

// File: tb/tb_cdc_fifo_read_streamer.sv
// Bench for cdc_fifo_read_streamer: model FIFO with registered read data, scoreboard monitor, directed and random phases.
module tb_cdc_fifo_read_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fifo_empty;
  logic        m_ready;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_inc;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] rd_count;
  logic        fifo_rd_inc_n;
  logic        m_valid_n;
  logic [7:0]  m_data_n;
  logic [3:0]  rd_count_n;

  cdc_fifo_read_streamer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_inc(fifo_rd_inc),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .rd_count(rd_count)
  );

  cdc_fifo_read_streamer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_inc(fifo_rd_inc_n),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid_n), .m_ready(m_ready),
    .m_data(m_data_n), .rd_count(rd_count_n)
  );

  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  next_data;
  bit          have_next = 1'b0;
  bit          rst_ctl = 1'b0;
  bit          ready_ctl = 1'b0;
  bit          gap_ctl = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          inc_cnt, valid_cnt, gap_cnt;
  bit          seen_valid, prev_valid_obs;
  int unsigned model_count = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_stats();
    inc_cnt = 0; valid_cnt = 0; gap_cnt = 0; seen_valid = 1'b0; prev_valid_obs = 1'b0;
  endtask

  // One clock: drive inputs on the falling edge, then observe the settled combinational outputs.
  task automatic step();
    @(negedge clk);
    rst_n        = rst_ctl;
    m_ready      = ready_ctl;
    fifo_rd_data = have_next ? next_data : 8'($urandom);
    fifo_empty   = gap_ctl || (src_q.size() == 0);
    #1;
    have_next = 1'b0;
    if (fifo_rd_inc) begin
      inc_cnt++;
      if (src_q.size() > 0) begin
        next_data = src_q.pop_front();
        have_next = 1'b1;
      end
    end
    if (m_valid) begin
      valid_cnt++;
      if (seen_valid && !prev_valid_obs) gap_cnt++;
      seen_valid = 1'b1;
    end
    prev_valid_obs = m_valid;
  endtask

  task automatic do_reset(input int cycles);
    rst_ctl = 1'b0;
    src_q.delete();
    exp_q.delete();
    have_next = 1'b0;
    gap_ctl = 1'b0;
    repeat (cycles) step();
    rst_ctl = 1'b1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int k = 0;
    while ((exp_q.size() != 0) && (k < max_cycles)) begin
      step();
      k++;
    end
    check(name, exp_q.size(), 0);
    step();
  endtask

  // Monitor: compares every accepted word against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    #2;
    if (fifo_rd_inc) check("rd_inc_while_empty", fifo_empty, 1'b0);
    check("w4_rd_inc_match", fifo_rd_inc_n, fifo_rd_inc);
    if (prev_stall) begin
      check("stall_hold_valid", m_valid, 1'b1);
      check("stall_hold_data", m_data, prev_data);
    end
    if (!rst_n) begin
      model_count = 0;
      prev_stall  = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: actual=%0h expected=none", m_data);
        end else begin
          check("word_order", m_data, exp_q.pop_front());
        end
        check("rd_count_at_pop", rd_count, model_count[15:0]);
        check("rd_count_w4_at_pop", rd_count_n, model_count[3:0]);
        model_count++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0; fifo_rd_data = 8'h00;

    // Idle after reset
    do_reset(2);
    clear_stats();
    repeat (10) step();
    check("t1_rd_inc_cycles", inc_cnt, 0);
    check("t1_m_valid", m_valid, 1'b0);
    check("t1_rd_count", rd_count, 16'd0);
    check("t1_m_data", m_data, 8'h00);
    check("t1_rd_count_w4", rd_count_n, 4'd0);

    // Single word latency
    ready_ctl = 1'b1;
    load(8'hA5);
    step();
    check("t2_inc_N", fifo_rd_inc, 1'b1);
    check("t2_valid_N", m_valid, 1'b0);
    step();
    check("t2_inc_N1", fifo_rd_inc, 1'b0);
    check("t2_valid_N1", m_valid, 1'b0);
    step();
    check("t2_valid_N2", m_valid, 1'b1);
    check("t2_data_N2", m_data, 8'hA5);
    step();
    check("t2_valid_after_pop", m_valid, 1'b0);
    check("t2_rd_count", rd_count, 16'd1);

    // 16-word burst at full rate
    do_reset(2);
    ready_ctl = 1'b1;
    for (int i = 0; i < 16; i++) load(8'(i));
    clear_stats();
    repeat (30) step();
    check("t3_inc_cycles", inc_cnt, 16);
    check("t3_valid_cycles", valid_cnt, 16);
    check("t3_gaps", gap_cnt, 0);
    check("t3_rd_count", rd_count, 16'd16);
    check("t3_drained", exp_q.size(), 0);

    // Backpressure from the start
    do_reset(2);
    ready_ctl = 1'b0;
    for (int i = 0; i < 16; i++) load(8'(i));
    clear_stats();
    repeat (10) step();
    check("t4_inc_stalled", inc_cnt, 2);
    check("t4_valid_stalled", m_valid, 1'b1);
    check("t4_data_stalled", m_data, 8'h00);
    ready_ctl = 1'b1;
    drain("t4_drained", 100);
    check("t4_inc_total", inc_cnt, 16);
    check("t4_rd_count", rd_count, 16'd16);

    // Random backpressure and empty gaps
    do_reset(2);
    for (int i = 0; i < 200; i++) load(8'($urandom));
    begin
      int k = 0;
      while ((exp_q.size() != 0) && (k < 3000)) begin
        ready_ctl = 1'($urandom_range(0, 1));
        gap_ctl   = ($urandom_range(0, 3) == 0);
        step();
        k++;
      end
    end
    gap_ctl = 1'b0;
    ready_ctl = 1'b1;
    check("t5_drained", exp_q.size(), 0);
    step();
    check("t5_rd_count", rd_count, 16'd200);

    // Reset with a buffered word and a word in flight
    ready_ctl = 1'b0;
    for (int i = 0; i < 4; i++) load(8'h10 + 8'(i));
    step();
    step();
    step();
    check("t6_valid_before_reset", m_valid, 1'b1);
    check("t6_count_before_reset", rd_count, 16'd200);
    do_reset(1);
    step();
    check("t6_valid_after_reset", m_valid, 1'b0);
    check("t6_rd_count_after_reset", rd_count, 16'd0);
    check("t6_m_data_after_reset", m_data, 8'h00);
    ready_ctl = 1'b1;
    for (int i = 0; i < 8; i++) load(8'h60 + 8'(i));
    drain("t6_drained", 60);
    check("t6_rd_count", rd_count, 16'd8);

    // Counter wrap on the 4-bit instance
    do_reset(2);
    ready_ctl = 1'b1;
    for (int i = 0; i < 17; i++) load(8'hC0 + 8'(i));
    drain("t7_drained", 80);
    check("t7_rd_count_16", rd_count, 16'd17);
    check("t7_rd_count_w4", rd_count_n, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
